// File: rtl/tmr_fault_monitor_if.sv
// rtl/tmr_fault_monitor_if.sv - sample inputs and status outputs of the TMR fault monitor
interface tmr_fault_monitor_if #(
  parameter int WIDTH     = 64,
  parameter int CNT_WIDTH = 16
);
  logic                 enable;
  logic [WIDTH-1:0]     q_1;
  logic [WIDTH-1:0]     q_2;
  logic [WIDTH-1:0]     q_3;
  logic [WIDTH-1:0]     voted_q;
  logic                 clr;
  logic                 irq_ack;
  logic [2:0]           fault_vec;
  logic [CNT_WIDTH-1:0] err_cnt_1;
  logic [CNT_WIDTH-1:0] err_cnt_2;
  logic [CNT_WIDTH-1:0] err_cnt_3;
  logic [2:0]           persist_vec;
  logic                 no_majority;
  logic [1:0]           health;
  logic                 irq;

  modport master (
    output enable, q_1, q_2, q_3, voted_q, clr, irq_ack,
    input  fault_vec, err_cnt_1, err_cnt_2, err_cnt_3, persist_vec,
           no_majority, health, irq
  );

  modport slave (
    input  enable, q_1, q_2, q_3, voted_q, clr, irq_ack,
    output fault_vec, err_cnt_1, err_cnt_2, err_cnt_3, persist_vec,
           no_majority, health, irq
  );
endinterface

// File: rtl/tmr_fault_monitor.sv
// rtl/tmr_fault_monitor.sv - classifies replica/voter mismatches, counts events, tracks health
module tmr_fault_monitor #(
  parameter int WIDTH          = 64,
  parameter int CNT_WIDTH      = 16,
  parameter int PERSIST_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  tmr_fault_monitor_if.slave   bus
);
  localparam int RUN_W = $clog2(PERSIST_CYCLES + 1);
  localparam logic [RUN_W-1:0]     RUN_MAX = RUN_W'(PERSIST_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    H_OK       = 2'b00,
    H_DEGRADED = 2'b01,
    H_FAILED   = 2'b10
  } health_t;

  health_t              health_q, health_d;
  logic [2:0]           fault_q, fault_d;
  logic [CNT_WIDTH-1:0] err_q [3];
  logic [CNT_WIDTH-1:0] err_d [3];
  logic [RUN_W-1:0]     run_q [3];
  logic [RUN_W-1:0]     run_d [3];
  logic [2:0]           persist_q, persist_d;
  logic                 nomaj_q, nomaj_d;
  logic                 irq_q, irq_d;
  logic [2:0]           mism;
  logic                 nm;

  always_comb begin
    mism[0] = (bus.q_1 != bus.voted_q);
    mism[1] = (bus.q_2 != bus.voted_q);
    mism[2] = (bus.q_3 != bus.voted_q);
    nm      = (bus.q_1 != bus.q_2) && (bus.q_1 != bus.q_3) && (bus.q_2 != bus.q_3);
  end

  always_comb begin
    fault_d   = fault_q;
    persist_d = persist_q;
    nomaj_d   = nomaj_q;
    health_d  = health_q;
    irq_d     = irq_q;
    for (int i = 0; i < 3; i++) begin
      err_d[i] = err_q[i];
      run_d[i] = run_q[i];
    end

    if (bus.enable) begin
      fault_d = mism;
      nomaj_d = nomaj_q | nm;
      for (int i = 0; i < 3; i++) begin
        // fault_q holds the previous sample's mismatch, so a run counts once at its start
        if (mism[i] && !fault_q[i] && (err_q[i] != CNT_MAX))
          err_d[i] = err_q[i] + CNT_WIDTH'(1);
        if (!mism[i])
          run_d[i] = '0;
        else if (run_q[i] != RUN_MAX)
          run_d[i] = run_q[i] + RUN_W'(1);
        if (mism[i] && (run_d[i] == RUN_MAX))
          persist_d[i] = 1'b1;
      end

      // Health looks at the sticky values being written on this same edge
      case (health_q)
        H_OK, H_DEGRADED: begin
          if (nomaj_d || ($countones(persist_d) >= 2))
            health_d = H_FAILED;
          else if ((health_q == H_OK) && ($countones(persist_d) == 1))
            health_d = H_DEGRADED;
        end
        default: health_d = H_FAILED;
      endcase
    end

    // Health only ever moves to a worse state, so any change is a worsening
    if (health_d != health_q)
      irq_d = 1'b1;
    else if (bus.irq_ack)
      irq_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      health_q  <= H_OK;
      fault_q   <= '0;
      persist_q <= '0;
      nomaj_q   <= 1'b0;
      irq_q     <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        err_q[i] <= '0;
        run_q[i] <= '0;
      end
    end else begin
      health_q  <= health_d;
      fault_q   <= fault_d;
      persist_q <= persist_d;
      nomaj_q   <= nomaj_d;
      irq_q     <= irq_d;
      for (int i = 0; i < 3; i++) begin
        err_q[i] <= err_d[i];
        run_q[i] <= run_d[i];
      end
    end
  end

  assign bus.fault_vec   = fault_q;
  assign bus.err_cnt_1   = err_q[0];
  assign bus.err_cnt_2   = err_q[1];
  assign bus.err_cnt_3   = err_q[2];
  assign bus.persist_vec = persist_q;
  assign bus.no_majority = nomaj_q;
  assign bus.health      = health_q;
  assign bus.irq         = irq_q;
endmodule

// File: tb/tb_tmr_fault_monitor.sv
// tb/tb_tmr_fault_monitor.sv - directed vector bench for tmr_fault_monitor
module tb_tmr_fault_monitor;
  localparam int W  = 64;
  localparam int CW = 4;
  localparam int PC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tmr_fault_monitor_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

  tmr_fault_monitor #(.WIDTH(W), .CNT_WIDTH(CW), .PERSIST_CYCLES(PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected outputs packed as {fault_vec, err1, err2, err3, persist_vec, no_majority, health, irq}
  typedef struct {
    string       name;
    logic        en;
    logic        clr;
    logic        ack;
    logic [W-1:0] q1, q2, q3, v;
    logic [21:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  function automatic logic [21:0] pk(int fv, int e1, int e2, int e3, int pv, int nm, int h, int irq);
    return {3'(fv), 4'(e1), 4'(e2), 4'(e3), 3'(pv), 1'(nm), 2'(h), 1'(irq)};
  endfunction

  task automatic add(string name, int en, int q1, int q2, int q3, int v, int clr, int ack,
                     logic [21:0] exp);
    vec_t r;
    r.name = name;
    r.en   = (en != 0);
    r.clr  = (clr != 0);
    r.ack  = (ack != 0);
    r.q1   = W'(q1);
    r.q2   = W'(q2);
    r.q3   = W'(q3);
    r.v    = W'(v);
    r.exp  = exp;
    vecs.push_back(r);
  endtask

  task automatic drive(int r, int en, int q1, int q2, int q3, int v, int clr, int ack);
    rst         = (r != 0);
    bus.enable  = (en != 0);
    bus.q_1     = W'(q1);
    bus.q_2     = W'(q2);
    bus.q_3     = W'(q3);
    bus.voted_q = W'(v);
    bus.clr     = (clr != 0);
    bus.irq_ack = (ack != 0);
  endtask

  task automatic check(string name, logic [21:0] exp);
    logic [21:0] act;
    act = {bus.fault_vec, bus.err_cnt_1, bus.err_cnt_2, bus.err_cnt_3,
           bus.persist_vec, bus.no_majority, bus.health, bus.irq};
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(string name, logic [21:0] exp);
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  initial begin
    int exp_cnt;

    drive(1, 0, 5, 5, 5, 5, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset", pk(0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 10; i++)
      add("t1_equal", 1, 5, 5, 5, 5, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add("t2_q2_glitch", 1, 5, 7, 5, 5, 0, 0, pk(2, 0, 1, 0, 0, 0, 0, 0));
    add("t2_recover",   1, 5, 5, 5, 5, 0, 0, pk(0, 0, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      add("t3_q3_run",  1, 5, 5, 9, 5, 0, 0, pk(4, 0, 1, 1, 0, 0, 0, 0));
    add("t3_q3_persist", 1, 5, 5, 9, 5, 0, 0, pk(4, 0, 1, 1, 4, 0, 1, 1));
    add("t3_ack",        1, 5, 5, 5, 5, 0, 1, pk(0, 0, 1, 1, 4, 0, 1, 0));
    add("t4_no_majority", 1, 1, 2, 3, 3, 0, 0, pk(3, 1, 2, 1, 4, 1, 2, 1));
    add("t4_ack",         1, 5, 5, 5, 5, 0, 1, pk(0, 1, 2, 1, 4, 1, 2, 0));
    add("t4_clr",         1, 5, 7, 5, 5, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      add("t4_q3_run",    1, 5, 5, 9, 5, 0, 0, pk(4, 0, 0, 1, 0, 0, 0, 0));
    add("t4_q3_persist",  1, 5, 5, 9, 5, 0, 0, pk(4, 0, 0, 1, 4, 0, 1, 1));
    add("t4_ack_with_worsen", 1, 1, 2, 3, 3, 0, 1, pk(3, 1, 1, 1, 4, 1, 2, 1));
    add("t4_ack_after",   1, 5, 5, 5, 5, 0, 1, pk(0, 1, 1, 1, 4, 1, 2, 0));
    add("t4_ack_idle",    1, 5, 5, 5, 5, 0, 1, pk(0, 1, 1, 1, 4, 1, 2, 0));
    add("t6_clr_disabled", 0, 5, 5, 5, 5, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add("t6_s1",          1, 5, 7, 5, 5, 0, 0, pk(2, 0, 1, 0, 0, 0, 0, 0));
    add("t6_hold1",       0, 5, 7, 5, 5, 0, 0, pk(2, 0, 1, 0, 0, 0, 0, 0));
    add("t6_s2",          1, 5, 7, 5, 5, 0, 0, pk(2, 0, 1, 0, 0, 0, 0, 0));
    add("t6_hold_equal",  0, 5, 5, 5, 5, 0, 0, pk(2, 0, 1, 0, 0, 0, 0, 0));
    add("t6_s3",          1, 5, 7, 5, 5, 0, 0, pk(2, 0, 1, 0, 0, 0, 0, 0));
    add("t6_hold3",       0, 5, 7, 5, 5, 0, 0, pk(2, 0, 1, 0, 0, 0, 0, 0));
    add("t6_s4_persist",  1, 5, 7, 5, 5, 0, 0, pk(2, 0, 1, 0, 2, 0, 1, 1));
    add("t6_clr_mismatch", 1, 5, 7, 5, 5, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
    add("t6_new_event",   1, 5, 7, 5, 5, 0, 0, pk(2, 0, 1, 0, 0, 0, 0, 0));

    foreach (vecs[k]) begin
      drive(0, vecs[k].en, 0, 0, 0, 0, vecs[k].clr, vecs[k].ack);
      bus.q_1     = vecs[k].q1;
      bus.q_2     = vecs[k].q2;
      bus.q_3     = vecs[k].q3;
      bus.voted_q = vecs[k].v;
      step(vecs[k].name, vecs[k].exp);
    end

    // rst in the middle of a q_2 run: the run restarts and needs a full PC samples again
    drive(0, 1, 5, 7, 5, 5, 0, 0);
    step("rst_run2", pk(2, 0, 1, 0, 0, 0, 0, 0));
    step("rst_run3", pk(2, 0, 1, 0, 0, 0, 0, 0));
    drive(1, 1, 5, 7, 5, 5, 0, 0);
    step("rst_mid_run", pk(0, 0, 0, 0, 0, 0, 0, 0));
    drive(0, 1, 5, 7, 5, 5, 0, 0);
    for (int i = 0; i < PC - 1; i++)
      step("rst_new_run", pk(2, 0, 1, 0, 0, 0, 0, 0));
    step("rst_new_persist", pk(2, 0, 1, 0, 2, 0, 1, 1));

    // Saturation of err_cnt_1 with repeated single-sample mismatches
    drive(0, 0, 5, 5, 5, 5, 1, 0);
    step("sat_clr", pk(0, 0, 0, 0, 0, 0, 0, 0));
    exp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 8, 5, 5, 5, 0, 0);
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      step("sat_mismatch", pk(1, exp_cnt, 0, 0, 0, 0, 0, 0));
      drive(0, 1, 5, 5, 5, 5, 0, 0);
      step("sat_equal", pk(0, exp_cnt, 0, 0, 0, 0, 0, 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
